regfile_param: RTL



---
 rtl/regfile_param_if.sv | 30 +++
 rtl/regfile_param.sv | 123 ++++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// Register-file access bundle between the control unit (master) and the register file (slave).
// Carries write, read, reservation and status signals; clock and reset stay outside.
interface regfile_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              Ready;
  logic              RegWre;
  logic [1:0]        RegDst;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Reserve;
  logic [ADDR_W-1:0] ReserveReg;
  logic              Busy1;
  logic              Busy2;

  modport master (
    output RegWre, RegDst, rs, rt, rd, WriteData, Reserve, ReserveReg,
    input  Ready, ReadData1, ReadData2, Busy1, Busy2
  );

  modport slave (
    input  RegWre, RegDst, rs, rt, rd, WriteData, Reserve, ReserveReg,
    output Ready, ReadData1, ReadData2, Busy1, Busy2
  );
endinterface

// File: rtl/regfile_param.sv
// MIPS register file with registered read ports, optional write-to-read bypass, a post-reset
// clear sequencer and a per-register busy scoreboard for pending-write stalls.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31,
  parameter bit          BYPASS   = 1'b1
) (
  input logic            CLK,
  input logic            RST,
  regfile_param_if.slave bus
);

  localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;

  logic [ADDR_W-1:0]   wr_addr;
  logic                commit;
  logic                reserve;

  always_comb begin
    unique case (bus.RegDst)
      2'b00:   wr_addr = LinkAddr;
      2'b01:   wr_addr = bus.rt;
      default: wr_addr = bus.rd;
    endcase
  end

  // Register 0 is never written and never reserved.
  assign commit  = bus.RegWre && ready_q && (wr_addr != '0);
  assign reserve = bus.Reserve && ready_q && (bus.ReserveReg != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    unique case (state_q)
      StClear: begin
        regs_d[ptr_q] = '0;
        rd1_d         = '0;
        rd2_d         = '0;
        if (ptr_q == LastAddr) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StRun: begin
        ready_d = 1'b1;
        if (commit) begin
          regs_d[wr_addr] = bus.WriteData;
          busy_d[wr_addr] = 1'b0;
        end
        // A fresh reservation wins over a same-edge commit: a new producer was issued.
        if (reserve) begin
          busy_d[bus.ReserveReg] = 1'b1;
        end
        if (bus.rs == '0) begin
          rd1_d = '0;
        end else if (BYPASS && commit && (wr_addr == bus.rs)) begin
          rd1_d = bus.WriteData;
        end else begin
          rd1_d = regs_q[bus.rs];
        end
        if (bus.rt == '0) begin
          rd2_d = '0;
        end else if (BYPASS && commit && (wr_addr == bus.rt)) begin
          rd2_d = bus.WriteData;
        end else begin
          rd2_d = regs_q[bus.rt];
        end
      end
      default: begin
        state_d = StClear;
        ptr_d   = '0;
      end
    endcase
  end

  // The array itself has no reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StClear;
      ptr_q   <= '0;
      busy_q  <= '0;
      ready_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  assign bus.Ready     = ready_q;
  assign bus.ReadData1 = rd1_q;
  assign bus.ReadData2 = rd2_q;
  assign bus.Busy1     = busy_q[bus.rs];
  assign bus.Busy2     = busy_q[bus.rt];

endmodule
